// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: FSM state encoding, word geometry, byte-lane insertion helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a free queue slot before starting a word
    REQ   = 2'd1,  // memReq high, waiting for the MMU to go busy
    WAIT  = 2'd2,  // MMU busy, waiting for read data
    DRAIN = 2'd3   // abandoned transaction, waiting for the MMU to go idle
  } fetch_state_t;

  localparam int BEATS_PER_WORD = 4;
  localparam int INSTR_WIDTH    = 32;

  // Big-endian lane placement: lane 0 lands in [31:24], lane 3 in [7:0].
  function automatic logic [INSTR_WIDTH-1:0] insert_byte(
    input logic [INSTR_WIDTH-1:0] word,
    input logic [1:0]             lane,
    input logic [7:0]             data
  );
    logic [INSTR_WIDTH-1:0] r;
    r = word;
    case (lane)
      2'd0:    r[31:24] = data;
      2'd1:    r[23:16] = data;
      2'd2:    r[15:8]  = data;
      default: r[7:0]   = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO holding {instruction, pc} entries.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle;
//   pop ignored when empty; flush overrides push and pop.
// Ports: clk, reset (async high), push/push_data, pop, flush -> head, full, empty, count.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = storage[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: walks the PC, reads 4 bytes per instruction over the MMU
//   req/busy handshake, assembles big-endian words into a prefetch queue.
// Latency: one MMU transaction per byte; word at instrValid the cycle after push.
// Backpressure: new words start only when the queue has a free slot;
//   instrReady=0 lets the queue fill and then memReq stays low.
// Ports: clk, reset; redirect/redirectPc; memAddr/memReq/memBusy/memData (MMU A);
//   instrValid/instr/instrPc/instrReady (decoder side).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     BUS_WIDTH     = 8,
  parameter int                     QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirectPc,
  output logic [ADDRESS_WIDTH-1:0] memAddr,
  output logic                     memReq,
  input  logic                     memBusy,
  input  logic [BUS_WIDTH-1:0]     memData,
  output logic                     instrValid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] instrPc,
  input  logic                     instrReady
);

  localparam int QW    = INSTR_WIDTH + ADDRESS_WIDTH;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [1:0]               beat;
  logic [INSTR_WIDTH-1:0]   word_buf;
  logic [INSTR_WIDTH-1:0]   assembled;
  logic                     capture;
  logic                     push_word;
  logic                     last_beat;
  logic                     pop_head;
  logic                     room_after_push;
  logic [QW-1:0]            q_head;
  logic                     q_full;
  logic                     q_empty;
  logic [CNT_W-1:0]         q_count;

  assign last_beat = (beat == 2'(BEATS_PER_WORD - 1));
  assign assembled = insert_byte(word_buf, beat, memData[7:0]);
  assign memAddr   = fetch_pc + ADDRESS_WIDTH'(beat);
  assign memReq    = (state == REQ);
  assign pop_head  = instrValid & instrReady;
  // After a push the queue still has room if it was below DEPTH-1 or the
  // decoder is popping in the same cycle.
  assign room_after_push = (q_count < CNT_W'(QUEUE_DEPTH - 1)) | pop_head;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    push_word  = 1'b0;
    case (state)
      IDLE: if (!q_full) state_next = REQ;
      REQ:  if (memBusy) state_next = WAIT;
      WAIT: begin
        if (!memBusy) begin
          capture = 1'b1;
          if (last_beat) begin
            push_word  = 1'b1;
            state_next = room_after_push ? REQ : IDLE;
          end else begin
            state_next = REQ;
          end
        end
      end
      DRAIN: if (!memBusy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Redirect wins over everything; an open MMU transaction must be drained
    // before a new request so its late data is never mistaken for ours.
    if (redirect) begin
      capture    = 1'b0;
      push_word  = 1'b0;
      state_next = (state == IDLE) ? IDLE : DRAIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      beat     <= '0;
      word_buf <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= redirectPc;
        beat     <= '0;
      end else if (capture) begin
        word_buf <= assembled;
        beat     <= beat + 2'd1;  // wraps to 0 after the last lane
        if (last_beat) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(BEATS_PER_WORD);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_word),
    .push_data ({assembled, fetch_pc}),
    .pop       (pop_head),
    .flush     (redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign instrValid = ~q_empty;
  assign instr      = instrValid ? q_head[QW-1 -: INSTR_WIDTH] : '0;
  assign instrPc    = instrValid ? q_head[ADDRESS_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a behavioural MMU whose
// byte at address a is a[7:0], so the word at PC p is {p, p+1, p+2, p+3} low bytes.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic [31:0] memAddr;
  logic        memReq;
  logic        memBusy = 1'b0;
  logic [7:0]  memData = '0;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int mmu_lat = 1;
  int mmu_cnt = 0;
  int bad_req = 0;
  logic [31:0] mmu_addr = '0;
  logic [31:0] req_log[$];
  logic [31:0] pop_instr[$];
  logic [31:0] pop_pc[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .memAddr    (memAddr),
    .memReq     (memReq),
    .memBusy    (memBusy),
    .memData    (memData),
    .instrValid (instrValid),
    .instr      (instr),
    .instrPc    (instrPc),
    .instrReady (instrReady)
  );

  // MMU model: accepts a request on the falling edge, stays busy mmu_lat+1
  // falling edges, then drops busy with the data byte already on memData.
  initial begin
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        memBusy = 1'b0;
      end else begin
        if (memReq && memBusy) bad_req++;
        if (memBusy) begin
          if (mmu_cnt == 0) begin
            memBusy = 1'b0;
            memData = mmu_addr[7:0];
          end else begin
            mmu_cnt--;
          end
        end else if (memReq) begin
          memBusy  = 1'b1;
          mmu_addr = memAddr;
          mmu_cnt  = mmu_lat;
          req_log.push_back(memAddr);
        end
      end
    end
  end

  // Pop monitor, sampled just before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset && !redirect && instrValid && instrReady) begin
        pop_instr.push_back(instr);
        pop_pc.push_back(instrPc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    pop_instr.delete();
    pop_pc.delete();
    bad_req = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    instrReady = 1'b0;
    mmu_lat = 1;
    repeat (2) @(posedge clk);
    clear_logs();
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int c = 0;
    while (req_log.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    compared++;
    if (req_log.size() < n) begin
      mismatched++;
      $display("FAIL wait_reqs: got %0d requests, required %0d", req_log.size(), n);
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (pop_pc.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    compared++;
    if (pop_pc.size() < n) begin
      mismatched++;
      $display("FAIL wait_pops: got %0d pops, required %0d", pop_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("FAIL reset_memReq: got %b required 0", memReq); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("FAIL reset_instrValid: got %b required 0", instrValid); end
    compared++; if (instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h required 0", instr); end
    compared++; if (instrPc !== 32'h0) begin mismatched++; $display("FAIL reset_instrPc: got %h required 0", instrPc); end
    compared++; if (memAddr !== 32'h0) begin mismatched++; $display("FAIL reset_memAddr: got %h required 0", memAddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00010203;
    exp_w[1] = 32'h04050607;
    exp_w[2] = 32'h08090A0B;
    do_reset();
    instrReady = 1'b1;
    wait_pops(3, 300);
    wait_reqs(12, 100);
    for (int i = 0; i < 3; i++) begin
      compared++; if (at(pop_instr, i) !== exp_w[i]) begin mismatched++; $display("FAIL seq_word%0d: got %h required %h", i, at(pop_instr, i), exp_w[i]); end
      compared++; if (at(pop_pc, i) !== 32'(4 * i)) begin mismatched++; $display("FAIL seq_pc%0d: got %h required %h", i, at(pop_pc, i), 4 * i); end
    end
    for (int i = 0; i < 12; i++) begin
      compared++; if (at(req_log, i) !== 32'(i)) begin mismatched++; $display("FAIL seq_addr%0d: got %h required %h", i, at(req_log, i), i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instrReady = 1'b0;
    wait_reqs(16, 400);
    repeat (40) @(posedge clk);
    #1;
    compared++; if (req_log.size() !== 16) begin mismatched++; $display("FAIL bp_req_count: got %0d required 16", req_log.size()); end
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("FAIL bp_memReq: got %b required 0", memReq); end
    compared++; if (instrValid !== 1'b1) begin mismatched++; $display("FAIL bp_instrValid: got %b required 1", instrValid); end
    compared++; if (instr !== 32'h00010203) begin mismatched++; $display("FAIL bp_head: got %h required 00010203", instr); end
    compared++; if (instrPc !== 32'h0) begin mismatched++; $display("FAIL bp_headPc: got %h required 0", instrPc); end
    instrReady = 1'b1;
    wait_reqs(17, 100);
    compared++; if (at(req_log, 16) !== 32'h10) begin mismatched++; $display("FAIL bp_resume_addr: got %h required 10", at(req_log, 16)); end
    wait_pops(4, 100);
    for (int i = 0; i < 4; i++) begin
      compared++; if (at(pop_pc, i) !== 32'(4 * i)) begin mismatched++; $display("FAIL bp_pop_pc%0d: got %h required %h", i, at(pop_pc, i), 4 * i); end
    end
  endtask

  task automatic test_redirect_mid_word();
    int c = 0;
    do_reset();
    mmu_lat = 3;
    instrReady = 1'b0;
    wait_reqs(7, 300);  // request for address 6 = beat 2 of the word at PC 4
    @(posedge clk);
    #1;
    compared++; if (memBusy !== 1'b1) begin mismatched++; $display("FAIL rd_busy_before: got %b required 1", memBusy); end
    compared++; if (instrValid !== 1'b1) begin mismatched++; $display("FAIL rd_valid_before: got %b required 1", instrValid); end
    redirect = 1'b1;
    redirectPc = 32'h100;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("FAIL rd_flush: got instrValid %b required 0", instrValid); end
    instrReady = 1'b1;
    while (memBusy && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    compared++; if (req_log.size() !== 7) begin mismatched++; $display("FAIL rd_drain_reqs: got %0d requests required 7", req_log.size()); end
    compared++; if (bad_req !== 0) begin mismatched++; $display("FAIL rd_req_while_busy: got %0d required 0", bad_req); end
    mmu_lat = 1;
    wait_pops(1, 200);
    compared++; if (at(pop_pc, 0) !== 32'h100) begin mismatched++; $display("FAIL rd_first_pc: got %h required 100", at(pop_pc, 0)); end
    compared++; if (at(pop_instr, 0) !== 32'h00010203) begin mismatched++; $display("FAIL rd_first_word: got %h required 00010203", at(pop_instr, 0)); end
    compared++; if (at(req_log, 7) !== 32'h100) begin mismatched++; $display("FAIL rd_first_addr: got %h required 100", at(req_log, 7)); end
  endtask

  task automatic test_push_pop_full();
    int c = 0;
    do_reset();
    instrReady = 1'b0;
    wait_reqs(16, 400);  // last beat of the fourth word is in flight, 3 words queued
    while (memBusy && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    compared++; if (instrValid !== 1'b1) begin mismatched++; $display("FAIL pp_valid: got %b required 1", instrValid); end
    instrReady = 1'b1;  // pop lands on the same edge as the fourth push
    @(posedge clk);
    #1;
    instrReady = 1'b0;
    compared++; if (instr !== 32'h04050607) begin mismatched++; $display("FAIL pp_head: got %h required 04050607", instr); end
    compared++; if (instrPc !== 32'h4) begin mismatched++; $display("FAIL pp_headPc: got %h required 4", instrPc); end
    wait_reqs(20, 200);
    repeat (40) @(posedge clk);
    #1;
    compared++; if (req_log.size() !== 20) begin mismatched++; $display("FAIL pp_req_count: got %0d required 20", req_log.size()); end
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("FAIL pp_memReq: got %b required 0", memReq); end
    instrReady = 1'b1;
    wait_pops(5, 100);
    for (int i = 0; i < 5; i++) begin
      compared++; if (at(pop_pc, i) !== 32'(4 * i)) begin mismatched++; $display("FAIL pp_pop_pc%0d: got %h required %h", i, at(pop_pc, i), 4 * i); end
    end
    compared++; if (at(pop_instr, 4) !== 32'h10111213) begin mismatched++; $display("FAIL pp_last_word: got %h required 10111213", at(pop_instr, 4)); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1;
    redirectPc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    instrReady = 1'b1;
    wait_pops(1, 200);
    wait_reqs(5, 100);
    compared++; if (at(pop_instr, 0) !== 32'hFCFDFEFF) begin mismatched++; $display("FAIL wrap_word: got %h required fcfdfeff", at(pop_instr, 0)); end
    compared++; if (at(pop_pc, 0) !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_pc: got %h required fffffffc", at(pop_pc, 0)); end
    compared++; if (at(req_log, 3) !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL wrap_addr3: got %h required ffffffff", at(req_log, 3)); end
    compared++; if (at(req_log, 4) !== 32'h0) begin mismatched++; $display("FAIL wrap_addr4: got %h required 0", at(req_log, 4)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mmu_lat = 3;
    instrReady = 1'b0;
    wait_reqs(6, 300);  // address 5: beat 1 of the word at PC 4
    @(posedge clk);
    #1;
    compared++; if (memAddr !== 32'h5) begin mismatched++; $display("FAIL ar_addr_before: got %h required 5", memAddr); end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (memAddr !== 32'h0) begin mismatched++; $display("FAIL ar_memAddr: got %h required 0", memAddr); end
    compared++; if (instrValid !== 1'b0) begin mismatched++; $display("FAIL ar_instrValid: got %b required 0", instrValid); end
    compared++; if (instr !== 32'h0) begin mismatched++; $display("FAIL ar_instr: got %h required 0", instr); end
    compared++; if (instrPc !== 32'h0) begin mismatched++; $display("FAIL ar_instrPc: got %h required 0", instrPc); end
    compared++; if (memReq !== 1'b0) begin mismatched++; $display("FAIL ar_memReq: got %b required 0", memReq); end
    clear_logs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mmu_lat = 1;
    instrReady = 1'b1;
    wait_pops(1, 200);
    compared++; if (at(req_log, 0) !== 32'h0) begin mismatched++; $display("FAIL ar_restart_addr: got %h required 0", at(req_log, 0)); end
    compared++; if (at(pop_pc, 0) !== 32'h0) begin mismatched++; $display("FAIL ar_restart_pc: got %h required 0", at(pop_pc, 0)); end
    compared++; if (at(pop_instr, 0) !== 32'h00010203) begin mismatched++; $display("FAIL ar_restart_word: got %h required 00010203", at(pop_instr, 0)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_mid_word();
    test_push_pop_full();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
